// File: rtl/uart_pkg.sv
// Shared UART definitions: transmit FSM state encoding and line levels.
// Intended for reuse by both the TX and RX engines.
package uart_pkg;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    FETCH  = 3'd1,
    LATCH  = 3'd2,
    START  = 3'd3,
    DATA   = 3'd4,
    PARITY = 3'd5,
    STOP   = 3'd6
  } tx_state_t;

  localparam logic UART_IDLE_LEVEL  = 1'b1;
  localparam logic UART_START_LEVEL = 1'b0;

endpackage

// File: rtl/uart_bit_timer.sv
// Loadable down-counter that times one serial bit; tick is high while the count is zero.
module uart_bit_timer
  import uart_pkg::*;
#(
  parameter int unsigned DIV_WIDTH = 16
) (
  input  logic                 i_clk,
  input  logic                 i_reset_n_w,
  input  logic                 i_load_w,
  input  logic [DIV_WIDTH-1:0] i_value_w,
  output logic                 o_tick_w
);

  logic [DIV_WIDTH-1:0] count_q;
  logic [DIV_WIDTH-1:0] count_d;

  always_comb begin
    count_d = count_q;
    if (i_load_w) begin
      count_d = i_value_w;
    end else if (count_q != '0) begin
      count_d = count_q - 1'b1;
    end
  end

  always_ff @(posedge i_clk) begin
    if (!i_reset_n_w) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign o_tick_w = (count_q == '0);

endmodule

// File: rtl/uart_tx_engine.sv
// UART transmitter: pops the TX fifo and serialises each byte LSB first as 8N1.
// Define UART_TX_PARITY_EN to insert an even parity bit between data and stop.
module uart_tx_engine
  import uart_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = 8,
  parameter int unsigned DIV_WIDTH  = 16
) (
  input  logic                  i_clk,
  input  logic                  i_reset_n_w,
  input  logic                  i_tx_en_w,
  input  logic [DIV_WIDTH-1:0]  i_baud_div_w,
  input  logic [DATA_WIDTH-1:0] i_fifo_data_w,
  input  logic                  i_fifo_empty_w,
  output logic                  o_fifo_read_w,
  output logic                  o_tx_w,
  output logic                  o_busy_w
);

  localparam int unsigned BIT_CNT_W = $clog2(DATA_WIDTH + 1);
  localparam logic [BIT_CNT_W-1:0] LAST_BIT = BIT_CNT_W'(DATA_WIDTH - 1);

  tx_state_t             state_q, state_d;
  logic [DATA_WIDTH-1:0] shift_q, shift_d;
  logic [DIV_WIDTH-1:0]  div_q, div_d;
  logic [BIT_CNT_W-1:0]  bit_cnt_q, bit_cnt_d;
  logic                  tx_q, tx_d;
  logic                  read_q, read_d;
  logic                  busy_q, busy_d;
`ifdef UART_TX_PARITY_EN
  logic                  parity_q, parity_d;
`endif

  logic                  start_ok;
  logic                  tick;
  logic                  timer_load;
  logic [DIV_WIDTH-1:0]  timer_value;

  uart_bit_timer #(
    .DIV_WIDTH(DIV_WIDTH)
  ) u_bit_timer (
    .i_clk       (i_clk),
    .i_reset_n_w (i_reset_n_w),
    .i_load_w    (timer_load),
    .i_value_w   (timer_value),
    .o_tick_w    (tick)
  );

  assign start_ok = i_tx_en_w && !i_fifo_empty_w;

  always_comb begin
    state_d     = state_q;
    shift_d     = shift_q;
    div_d       = div_q;
    bit_cnt_d   = bit_cnt_q;
    timer_load  = 1'b0;
    timer_value = div_q - 1'b1;
`ifdef UART_TX_PARITY_EN
    parity_d    = parity_q;
`endif

    case (state_q)
      IDLE: begin
        if (start_ok) state_d = FETCH;
      end
      FETCH: begin
        state_d = LATCH;
      end
      LATCH: begin
        shift_d     = i_fifo_data_w;
        div_d       = (i_baud_div_w == '0) ? DIV_WIDTH'(1) : i_baud_div_w;
        timer_load  = 1'b1;
        timer_value = div_d - 1'b1;
`ifdef UART_TX_PARITY_EN
        parity_d    = ^i_fifo_data_w;
`endif
        state_d     = START;
      end
      START: begin
        if (tick) begin
          state_d    = DATA;
          bit_cnt_d  = '0;
          timer_load = 1'b1;
        end
      end
      DATA: begin
        if (tick) begin
          timer_load = 1'b1;
          if (bit_cnt_q == LAST_BIT) begin
`ifdef UART_TX_PARITY_EN
            state_d = PARITY;
`else
            state_d = STOP;
`endif
          end else begin
            shift_d   = shift_q >> 1;
            bit_cnt_d = bit_cnt_q + 1'b1;
          end
        end
      end
`ifdef UART_TX_PARITY_EN
      PARITY: begin
        if (tick) begin
          state_d    = STOP;
          timer_load = 1'b1;
        end
      end
`endif
      STOP: begin
        if (tick) state_d = start_ok ? FETCH : IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    // Outputs are registered from the next state so the line level lines up with the state.
    read_d = (state_d == FETCH);
    busy_d = (state_d != IDLE);
    case (state_d)
      START:   tx_d = UART_START_LEVEL;
      DATA:    tx_d = shift_d[0];
`ifdef UART_TX_PARITY_EN
      PARITY:  tx_d = parity_q;
`endif
      default: tx_d = UART_IDLE_LEVEL;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (!i_reset_n_w) begin
      state_q   <= IDLE;
      shift_q   <= '0;
      div_q     <= '0;
      bit_cnt_q <= '0;
      tx_q      <= UART_IDLE_LEVEL;
      read_q    <= 1'b0;
      busy_q    <= 1'b0;
`ifdef UART_TX_PARITY_EN
      parity_q  <= 1'b0;
`endif
    end else begin
      state_q   <= state_d;
      shift_q   <= shift_d;
      div_q     <= div_d;
      bit_cnt_q <= bit_cnt_d;
      tx_q      <= tx_d;
      read_q    <= read_d;
      busy_q    <= busy_d;
`ifdef UART_TX_PARITY_EN
      parity_q  <= parity_d;
`endif
    end
  end

  assign o_fifo_read_w = read_q;
  assign o_tx_w        = tx_q;
  assign o_busy_w      = busy_q;

endmodule

// File: tb/tb_uart_tx_engine.sv
// Directed bench for uart_tx_engine with a behavioural fifo; frame bit orders are hand-written.
module tb_uart_tx_engine;

`ifdef UART_TX_PARITY_EN
  localparam int NB = 11;
`else
  localparam int NB = 10;
`endif

  logic        clk = 1'b0;
  logic        rst_n;
  logic        en;
  logic [15:0] div;
  logic [7:0]  fifo_data = 8'h00;
  logic        fifo_empty = 1'b1;
  logic        rd, tx, busy;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  uart_tx_engine #(
    .DATA_WIDTH(8),
    .DIV_WIDTH (16)
  ) dut (
    .i_clk          (clk),
    .i_reset_n_w    (rst_n),
    .i_tx_en_w      (en),
    .i_baud_div_w   (div),
    .i_fifo_data_w  (fifo_data),
    .i_fifo_empty_w (fifo_empty),
    .o_fifo_read_w  (rd),
    .o_tx_w         (tx),
    .o_busy_w       (busy)
  );

  // Fifo model: word is garbage during FETCH and becomes valid for the LATCH cycle.
  logic [7:0] q[$];
  logic [7:0] pending = 8'h00;
  bit         show = 1'b0;
  int         rd_cnt = 0;
  int         underflow = 0;

  always @(negedge clk) begin
    if (show) begin
      fifo_data = pending;
      show = 1'b0;
    end
    if (rd === 1'b1) begin
      rd_cnt++;
      if (q.size() == 0) begin
        underflow++;
      end else begin
        pending   = q.pop_front();
        fifo_data = ~pending;
        show      = 1'b1;
      end
    end
    fifo_empty = (q.size() == 0);
  end

  initial begin
    #3000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  typedef struct {
    logic [7:0]  data;
    logic [15:0] div;
    int          eff;
    logic [7:0]  seq;   // data bits in transmit order, seq[7] goes out first
    logic        par;
  } vec_t;

  vec_t tbl[6];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic push(input logic [7:0] b);
    q.push_back(b);
  endtask

  task automatic wait_read();
    bit ok;
    ok = 1'b0;
    for (int i = 0; i < 60; i++) begin
      @(negedge clk);
      if (rd === 1'b1) begin
        ok = 1'b1;
        break;
      end
    end
    chk("read_pulse_seen", 32'(ok), 32'd1);
    chk("fetch_tx_high", 32'(tx), 32'd1);
    chk("fetch_busy", 32'(busy), 32'd1);
  endtask

  task automatic after_fetch();
    @(negedge clk);
    chk("latch_read_low", 32'(rd), 32'd0);
    chk("latch_tx_high", 32'(tx), 32'd1);
  endtask

  task automatic check_frame(input logic [7:0] seq, input logic par, input int eff,
                             input logic [15:0] new_div);
    logic e;
    for (int b = 0; b < NB; b++) begin
      if (b == 0)           e = 1'b0;
      else if (b <= 8)      e = seq[8 - b];
      else if (b == NB - 1) e = 1'b1;
      else                  e = par;
      for (int c = 0; c < eff; c++) begin
        @(negedge clk);
        chk($sformatf("tx_bit%0d_cyc%0d", b, c), 32'(tx), 32'(e));
        chk($sformatf("busy_bit%0d_cyc%0d", b, c), 32'(busy), 32'd1);
        chk($sformatf("no_read_bit%0d_cyc%0d", b, c), 32'(rd), 32'd0);
        if (b == 0 && c == 0) div = new_div;
      end
    end
  endtask

  task automatic end_idle();
    @(negedge clk);
    chk("post_stop_busy_low", 32'(busy), 32'd0);
    chk("post_stop_tx_high", 32'(tx), 32'd1);
    chk("post_stop_no_read", 32'(rd), 32'd0);
  endtask

  task automatic run_vec(input vec_t v);
    int r0;
    r0  = rd_cnt;
    div = v.div;
    en  = 1'b1;
    push(v.data);
    wait_read();
    after_fetch();
    check_frame(v.seq, v.par, v.eff, v.div + 16'd3);
    end_idle();
    chk("vec_read_count", 32'(rd_cnt - r0), 32'd1);
  endtask

  initial begin
    int r0;
    tbl[0] = '{8'hA5, 16'd4, 4, 8'b10100101, 1'b0};
    tbl[1] = '{8'h07, 16'd3, 3, 8'b11100000, 1'b1};
    tbl[2] = '{8'h03, 16'd2, 2, 8'b11000000, 1'b0};
    tbl[3] = '{8'h12, 16'd1, 1, 8'b01001000, 1'b0};
    tbl[4] = '{8'h80, 16'd0, 1, 8'b00000001, 1'b1};
    tbl[5] = '{8'h3C, 16'd5, 5, 8'b00111100, 1'b0};

    // Reset held with a non-empty fifo
    rst_n = 1'b0;
    en    = 1'b1;
    div   = 16'd4;
    push(8'h81);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("reset_tx", 32'(tx), 32'd1);
      chk("reset_read", 32'(rd), 32'd0);
      chk("reset_busy", 32'(busy), 32'd0);
    end
    en    = 1'b0;
    rst_n = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("disabled_no_read", 32'(rd), 32'd0);
      chk("disabled_idle", 32'(busy), 32'd0);
    end
    en = 1'b1;
    wait_read();
    after_fetch();
    check_frame(8'b10000001, 1'b0, 4, 16'd4);
    end_idle();

    for (int i = 0; i < 6; i++) run_vec(tbl[i]);

    // Back-to-back frames with the 2-clock FETCH/LATCH gap
    div = 16'd2;
    r0  = rd_cnt;
    push(8'h00);
    push(8'hFF);
    wait_read();
    after_fetch();
    check_frame(8'h00, 1'b0, 2, 16'd2);
    @(negedge clk);
    chk("gap_fetch_read", 32'(rd), 32'd1);
    chk("gap_fetch_tx", 32'(tx), 32'd1);
    after_fetch();
    check_frame(8'hFF, 1'b0, 2, 16'd2);
    end_idle();
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      chk("empty_no_read", 32'(rd), 32'd0);
    end
    chk("b2b_read_count", 32'(rd_cnt - r0), 32'd2);

    // Reset during data bit 3, then the next byte goes out from a fresh start bit
    div = 16'd8;
    r0  = rd_cnt;
    push(8'h0F);
    push(8'h3C);
    wait_read();
    after_fetch();
    repeat (8 + 8 * 3 + 3) @(negedge clk);
    chk("busy_before_reset", 32'(busy), 32'd1);
    rst_n = 1'b0;
    @(negedge clk);
    chk("midreset_tx", 32'(tx), 32'd1);
    chk("midreset_busy", 32'(busy), 32'd0);
    chk("midreset_read", 32'(rd), 32'd0);
    rst_n = 1'b1;
    wait_read();
    after_fetch();
    check_frame(8'b00111100, 1'b0, 8, 16'd8);
    end_idle();
    chk("midreset_read_count", 32'(rd_cnt - r0), 32'd2);

    // Enable dropped mid-frame, then divisor changed mid-frame
    div = 16'd3;
    push(8'h12);
    push(8'h3C);
    wait_read();
    after_fetch();
    en = 1'b0;
    check_frame(8'b01001000, 1'b0, 3, 16'd3);
    end_idle();
    r0 = rd_cnt;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      chk("en_low_no_read", 32'(rd), 32'd0);
    end
    chk("en_low_read_count", 32'(rd_cnt - r0), 32'd0);
    en = 1'b1;
    wait_read();
    after_fetch();
    check_frame(8'b00111100, 1'b0, 3, 16'd9);
    end_idle();

    chk("no_underflow", 32'(underflow), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
